sseg_scan_driver: RTL and testbench
===================================

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits (legal range 2..8).
REQ-002 Parameter REFRESH_CYCLES, default 50000, clocks each digit is driven (legal minimum 2).
REQ-003 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1; reset is synchronous and active-high.
REQ-005 Port load, input, 1, single-cycle request to capture new display data.
REQ-006 Port hex_in, input, 4*N_DIGITS; nibble k is the hex value for digit k (digit 0 = least significant).
REQ-007 Port dp_in, input, N_DIGITS; bit k = 1 lights the decimal point of digit k.
REQ-008 Port blank_in, input, N_DIGITS; bit k = 1 forces digit k fully dark.
REQ-009 Port upd_pending, output, 1, high while captured data waits for the next frame boundary.
REQ-010 Port an, output, N_DIGITS, active-low digit enables.
REQ-011 Port sseg, output, 8, active-low segments; bit 7 = dp, bits 6..0 = g..a.

Function
REQ-012 The prescaler SHALL count 0..REFRESH_CYCLES-1 and wrap to 0; the digit index SHALL advance by 1 on each prescaler wrap.
REQ-013 The digit index SHALL wrap from N_DIGITS-1 to 0; that cycle is the frame boundary.
REQ-014 On load=1, hex_in/dp_in/blank_in SHALL be captured into a shadow register and upd_pending SHALL be 1 from the next cycle.
REQ-015 At a frame boundary with upd_pending=1, the shadow SHALL be copied into the display register and upd_pending SHALL clear.
REQ-016 load coincident with a frame-boundary transfer: the pre-edge shadow SHALL be transferred, the new data SHALL be captured into the shadow, and upd_pending SHALL remain 1.
REQ-017 load while upd_pending=1 (not at a boundary) SHALL overwrite the shadow; only the latest capture is displayed.
REQ-018 an and sseg SHALL be registered: one clock after the digit index changes, an has only bit [index] low and sseg shows that digit.
REQ-019 Decode (g..a, active-low): 0=40h 1=79h 2=24h 3=30h 4=19h 5=12h 6=02h 7=78h 8=00h 9=10h A=08h b=03h C=46h d=21h E=06h F=0Eh.
REQ-020 sseg[7] SHALL be the inverse of the displayed dp bit.
REQ-021 A blanked digit SHALL drive sseg=FFh; its an bit SHALL still be driven low in its slot.

Reset
REQ-022 reset SHALL clear the prescaler, digit index, shadow and display registers, and upd_pending to 0.
REQ-023 During and one cycle after reset, an SHALL be all ones and sseg SHALL be FFh.
REQ-024 reset asserted mid-frame or with a pending update SHALL discard the pending data; a load in the reset cycle SHALL be ignored.

Configuration
REQ-025 Macro SSEG_LEADING_ZERO_BLANK_EN defined: a digit k>0 SHALL be blanked when its nibble and all higher nibbles are 0 and its dp bit is 0.
REQ-026 Digit 0 SHALL never be auto-blanked.
REQ-027 Macro undefined: only blank_in controls blanking; zeros always display as 40h.

Structure
REQ-028 Shared package sseg_pkg SHALL hold the 16-entry segment constant table, the SSEG_OFF (FFh) constant, and the segment bit-index constants.
REQ-029 Sub-module sseg_digit_decode (4-bit hex, dp, blank -> 8-bit active-low sseg, combinational) SHALL be instantiated once on the muxed digit.
REQ-030 Counter widths SHALL be derived with $clog2 of REFRESH_CYCLES and N_DIGITS.

Verification (N_DIGITS=4, REFRESH_CYCLES=4)
REQ-031 Reset, then run 20 clocks with no load -> an cycles 1110,1101,1011,0111 every 4 clocks; sseg=40h throughout.
REQ-032 Load hex_in=1234h, dp_in=0010b, blank_in=0 mid-frame -> upd_pending=1 until the boundary; next frame shows digit0=19h, digit1=30h with sseg[7]=0, digit2=24h, digit3=79h.
REQ-033 Two loads (00AFh, then 00BEh) in one frame -> only 00BEh is displayed; 00AFh never appears.
REQ-034 Load exactly on the boundary cycle while pending -> old shadow is displayed this frame, new data next frame, upd_pending stays 1 across the boundary.
REQ-035 With SSEG_LEADING_ZERO_BLANK_EN, load 0070h -> digits 3,2 show FFh, digit1=78h, digit0=40h; without the macro digits 3,2 show 40h.
REQ-036 Assert reset mid-frame with pending 5555h -> an=1111b, sseg=FFh; after release, 5555h never displays and upd_pending=0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Segment encoding shared by the seven-segment scan driver: hex glyph table,
// all-dark constant and active-low segment bit positions (bit 7 = dp).
package sseg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SSEG_OFF = 8'hFF;

    // Packed so that SEG_TABLE[h] is the g..a pattern for hex value h.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/sseg_digit_decode.sv
// Combinational hex/dp/blank to active-low segment decode, zero latency.
// No flow control: output follows inputs within the same cycle.
module sseg_digit_decode
    import sseg_pkg::*;
(
    input  logic [3:0] i_hex,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_sseg
);

    logic [6:0] w_glyph;

    assign w_glyph = hex_glyph(i_hex);

    always_comb begin
        o_sseg = SSEG_OFF;
        if (!i_blank) begin
            o_sseg[SEG_A]  = w_glyph[0];
            o_sseg[SEG_B]  = w_glyph[1];
            o_sseg[SEG_C]  = w_glyph[2];
            o_sseg[SEG_D]  = w_glyph[3];
            o_sseg[SEG_E]  = w_glyph[4];
            o_sseg[SEG_F]  = w_glyph[5];
            o_sseg[SEG_G]  = w_glyph[6];
            o_sseg[SEG_DP] = ~i_dp;
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous display update.
// an/sseg registered one clock after the digit index; load is always accepted.
// Build option: SSEG_LEADING_ZERO_BLANK_EN enables leading-zero suppression.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    output logic                  upd_pending,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg
);

    localparam int PW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);

    logic [PW-1:0]         r_presc;
    logic [DW-1:0]         r_digit;

    logic [4*N_DIGITS-1:0] r_shd_hex;
    logic [N_DIGITS-1:0]   r_shd_dp;
    logic [N_DIGITS-1:0]   r_shd_blank;
    logic                  r_pend;

    logic [4*N_DIGITS-1:0] r_dsp_hex;
    logic [N_DIGITS-1:0]   r_dsp_dp;
    logic [N_DIGITS-1:0]   r_dsp_blank;

    logic [N_DIGITS-1:0]   r_an;
    logic [7:0]            r_sseg;

    logic                  w_presc_wrap;
    logic                  w_frame_bnd;
    logic [N_DIGITS-1:0]   w_lz_blank;
    logic [3:0]            w_cur_hex;
    logic                  w_cur_dp;
    logic                  w_cur_blank;
    logic [7:0]            w_dec_sseg;
    logic [N_DIGITS-1:0]   w_an_nxt;

    assign w_presc_wrap = (r_presc == PRESC_LAST);
    assign w_frame_bnd  = w_presc_wrap && (r_digit == DIGIT_LAST);

    // Refresh timebase and digit scan position.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_digit <= '0;
        end else begin
            r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
            if (w_presc_wrap) begin
                r_digit <= (r_digit == DIGIT_LAST) ? '0 : r_digit + 1'b1;
            end
        end
    end

    // Shadow capture; a load on the boundary lands after the transfer reads
    // the old shadow, so pending stays set for the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shd_hex   <= '0;
            r_shd_dp    <= '0;
            r_shd_blank <= '0;
            r_pend      <= 1'b0;
        end else if (load) begin
            r_shd_hex   <= hex_in;
            r_shd_dp    <= dp_in;
            r_shd_blank <= blank_in;
            r_pend      <= 1'b1;
        end else if (w_frame_bnd) begin
            r_pend      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dsp_hex   <= '0;
            r_dsp_dp    <= '0;
            r_dsp_blank <= '0;
        end else if (w_frame_bnd && r_pend) begin
            r_dsp_hex   <= r_shd_hex;
            r_dsp_dp    <= r_shd_dp;
            r_dsp_blank <= r_shd_blank;
        end
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic w_zero_run;

    // Walk down from the top digit; digit 0 is never suppressed.
    always_comb begin
        w_lz_blank = '0;
        w_zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            w_zero_run    = w_zero_run & (r_dsp_hex[4*k +: 4] == 4'h0);
            w_lz_blank[k] = w_zero_run & ~r_dsp_dp[k];
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    assign w_cur_hex   = r_dsp_hex[{r_digit, 2'b00} +: 4];
    assign w_cur_dp    = r_dsp_dp[r_digit];
    assign w_cur_blank = r_dsp_blank[r_digit] | w_lz_blank[r_digit];

    sseg_digit_decode u_decode (
        .i_hex   (w_cur_hex),
        .i_dp    (w_cur_dp),
        .i_blank (w_cur_blank),
        .o_sseg  (w_dec_sseg)
    );

    always_comb begin
        w_an_nxt          = '1;
        w_an_nxt[r_digit] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an   <= '1;
            r_sseg <= SSEG_OFF;
        end else begin
            r_an   <= w_an_nxt;
            r_sseg <= w_dec_sseg;
        end
    end

    assign an          = r_an;
    assign sseg        = r_sseg;
    assign upd_pending = r_pend;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver (4 digits, 4-clock refresh) against a frame-level
// reference model built from cycle counts since reset.
module tb_sseg_scan_driver;

    localparam int N  = 4;
    localparam int RC = 4;
    localparam int FR = N * RC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        upd_pending;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.N_DIGITS(N), .REFRESH_CYCLES(RC)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .hex_in      (hex_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .upd_pending (upd_pending),
        .an          (an),
        .sseg        (sseg)
    );

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: clocks since reset release, shadow/display contents.
    int          m_cyc = 0;
    int          m_idx = 0;
    logic [15:0] m_shd_hex = '0, m_dsp_hex = '0;
    logic [3:0]  m_shd_dp = '0, m_dsp_dp = '0;
    logic [3:0]  m_shd_blk = '0, m_dsp_blk = '0;
    logic        m_pend = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [7:0]  e_sseg = 8'hFF;
    logic [7:0]  obs [4];

    function automatic logic [7:0] ref_glyph(input int k, input logic [15:0] h,
                                             input logic [3:0] d, input logic [3:0] b);
        logic [3:0] nib = h[4*k +: 4];
        bit dark = b[k];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (k > 0 && (h >> (4*k)) == 16'h0 && !d[k]) dark = 1'b1;
`endif
        if (dark) return 8'hFF;
        return {~d[k], seg_ref[nib]};
    endfunction

    task automatic step(input logic rst, input logic ld, input logic [15:0] h,
                        input logic [3:0] d, input logic [3:0] b);
        reset = rst; load = ld; hex_in = h; dp_in = d; blank_in = b;
        @(posedge clk);
        if (rst) begin
            m_cyc = 0; m_pend = 1'b0;
            m_shd_hex = '0; m_shd_dp = '0; m_shd_blk = '0;
            m_dsp_hex = '0; m_dsp_dp = '0; m_dsp_blk = '0;
            e_an = 4'hF; e_sseg = 8'hFF;
        end else begin
            m_idx = (m_cyc / RC) % N;
            e_an = 4'hF;
            e_an[m_idx] = 1'b0;
            e_sseg = ref_glyph(m_idx, m_dsp_hex, m_dsp_dp, m_dsp_blk);
            if ((m_cyc % FR) == FR - 1 && m_pend) begin
                m_dsp_hex = m_shd_hex; m_dsp_dp = m_shd_dp; m_dsp_blk = m_shd_blk;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_shd_hex = h; m_shd_dp = d; m_shd_blk = b;
                m_pend = 1'b1;
            end
            m_cyc++;
        end
        #1;
    endtask

    task automatic idle_to(input int pos);
        int n = 0;
        while ((m_cyc % FR) != pos && n < 2*FR) begin
            step(0, 0, '0, '0, '0);
            n++;
        end
        checks++;
        if ((m_cyc % FR) != pos) begin errors++; $display("FAIL align: pos %0d want %0d", m_cyc % FR, pos); end
    endtask

    task automatic test_reset();
        step(1, 0, '0, '0, '0);
        step(1, 1, 16'hFFFF, 4'hF, 4'h0);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL reset_sseg: got %h want ff", sseg); end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b want 0", upd_pending); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] want;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, '0, '0, '0);
            want = 4'hF;
            want[(i / RC) % N] = 1'b0;
            checks++; if (an !== want) begin errors++; $display("FAIL idle_an[%0d]: got %b want %b", i, an, want); end
            checks++; if (sseg !== 8'hC0) begin errors++; $display("FAIL idle_sseg[%0d]: got %h want c0", i, sseg); end
        end
    endtask

    task automatic test_load_mid();
        int n = 0;
        step(0, 1, 16'h1234, 4'b0010, 4'b0000);
        while (m_pend && n < 2*FR) begin
            checks++; if (upd_pending !== 1'b1) begin errors++; $display("FAIL mid_pend: got %b want 1", upd_pending); end
            step(0, 0, '0, '0, '0);
            checks++; if (sseg !== e_sseg) begin errors++; $display("FAIL mid_wait_sseg: got %h want %h", sseg, e_sseg); end
            n++;
        end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL mid_clear: got %b want 0", upd_pending); end
        for (int i = 0; i < FR; i++) begin
            step(0, 0, '0, '0, '0);
            checks++; if (an !== e_an) begin errors++; $display("FAIL mid_an: got %b want %b", an, e_an); end
            obs[m_idx] = sseg;
        end
        checks++; if (obs[0] !== 8'h99) begin errors++; $display("FAIL mid_d0: got %h want 99", obs[0]); end
        checks++; if (obs[1] !== 8'h30) begin errors++; $display("FAIL mid_d1_dp: got %h want 30", obs[1]); end
        checks++; if (obs[2] !== 8'hA4) begin errors++; $display("FAIL mid_d2: got %h want a4", obs[2]); end
        checks++; if (obs[3] !== 8'hF9) begin errors++; $display("FAIL mid_d3: got %h want f9", obs[3]); end
    endtask

    task automatic test_double_load();
        idle_to(2);
        step(0, 1, 16'h00AF, 4'h0, 4'h0);
        step(0, 0, '0, '0, '0);
        step(0, 0, '0, '0, '0);
        step(0, 1, 16'h00BE, 4'h0, 4'h0);
        for (int i = 0; i < 3*FR; i++) begin
            step(0, 0, '0, '0, '0);
            checks++; if (sseg === 8'h8E || sseg === 8'h88) begin errors++; $display("FAIL dbl_stale: got %h want not 8e/88", sseg); end
            checks++; if (sseg !== e_sseg) begin errors++; $display("FAIL dbl_sseg: got %h want %h", sseg, e_sseg); end
            checks++; if (upd_pending !== m_pend) begin errors++; $display("FAIL dbl_pend: got %b want %b", upd_pending, m_pend); end
        end
    endtask

    task automatic test_boundary_load();
        idle_to(3);
        step(0, 1, 16'h1111, 4'h0, 4'h0);
        idle_to(FR - 1);
        step(0, 1, 16'h2222, 4'h0, 4'h0);
        checks++; if (upd_pending !== 1'b1) begin errors++; $display("FAIL bnd_pend: got %b want 1", upd_pending); end
        for (int i = 0; i < FR; i++) begin
            step(0, 0, '0, '0, '0);
            checks++; if (sseg !== 8'hF9) begin errors++; $display("FAIL bnd_old[%0d]: got %h want f9", i, sseg); end
            checks++; if (upd_pending !== (i < FR - 1)) begin errors++; $display("FAIL bnd_pend[%0d]: got %b want %b", i, upd_pending, (i < FR - 1)); end
        end
        for (int i = 0; i < FR; i++) begin
            step(0, 0, '0, '0, '0);
            checks++; if (sseg !== 8'hA4) begin errors++; $display("FAIL bnd_new[%0d]: got %h want a4", i, sseg); end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] hi;
        int n = 0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        hi = 8'hFF;
`else
        hi = 8'hC0;
`endif
        step(0, 1, 16'h0070, 4'h0, 4'h0);
        while (m_pend && n < 2*FR) begin step(0, 0, '0, '0, '0); n++; end
        for (int i = 0; i < FR; i++) begin
            step(0, 0, '0, '0, '0);
            obs[m_idx] = sseg;
        end
        checks++; if (obs[0] !== 8'hC0) begin errors++; $display("FAIL lz_d0: got %h want c0", obs[0]); end
        checks++; if (obs[1] !== 8'hF8) begin errors++; $display("FAIL lz_d1: got %h want f8", obs[1]); end
        checks++; if (obs[2] !== hi) begin errors++; $display("FAIL lz_d2: got %h want %h", obs[2], hi); end
        checks++; if (obs[3] !== hi) begin errors++; $display("FAIL lz_d3: got %h want %h", obs[3], hi); end
    endtask

    task automatic test_reset_mid();
        idle_to(6);
        step(0, 1, 16'h5555, 4'h0, 4'h0);
        step(0, 0, '0, '0, '0);
        step(1, 1, 16'h5555, 4'h0, 4'h0);
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rmid_an: got %b want 1111", an); end
        checks++; if (sseg !== 8'hFF) begin errors++; $display("FAIL rmid_sseg: got %h want ff", sseg); end
        checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL rmid_pend: got %b want 0", upd_pending); end
        step(0, 0, '0, '0, '0);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rmid_first_an: got %b want 1110", an); end
        for (int i = 0; i < 3*FR; i++) begin
            step(0, 0, '0, '0, '0);
            checks++; if (sseg === 8'h92) begin errors++; $display("FAIL rmid_stale: got %h want not 92", sseg); end
            checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL rmid_pend_after: got %b want 0", upd_pending); end
        end
    endtask

    task automatic test_random();
        logic r, l;
        logic [15:0] h;
        logic [3:0] d, b;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(63) == 0);
            l = ($urandom_range(5) == 0);
            h = 16'($urandom);
            if ($urandom_range(1) == 0) h = h & 16'h00FF;
            d = ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0;
            b = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            step(r, l, h, d, b);
            checks++; if (an !== e_an) begin errors++; $display("FAIL rnd_an[%0d]: got %b want %b", i, an, e_an); end
            checks++; if (sseg !== e_sseg) begin errors++; $display("FAIL rnd_sseg[%0d]: got %h want %h", i, sseg, e_sseg); end
            checks++; if (upd_pending !== m_pend) begin errors++; $display("FAIL rnd_pend[%0d]: got %b want %b", i, upd_pending, m_pend); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_mid();
        test_double_load();
        test_boundary_load();
        test_leading_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
